// File: rtl/stopwatch_1ms.sv
// Stopwatch core: 1 kHz tick extraction, two debounced push-buttons,
// and a 4-digit BCD elapsed-time counter under an IDLE/RUN/PAUSE FSM.
module stopwatch_1ms #(
  parameter int unsigned PRESC  = 10,
  parameter int unsigned DEB_MS = 20
) (
  input  logic        clk_in_50M,
  input  logic        reset,
  input  logic        clk_1k_in,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic        paused,
  output logic        wrap
);

  localparam logic [7:0] DEB_LIM  = 8'(DEB_MS);
  localparam logic [7:0] PRES_MAX = 8'(PRESC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  // Tick generation
  logic [2:0] k_sync_q;
  logic       tick;

  // Button debounce, index 0 = start, 1 = clear
  logic [1:0]      btn_raw;
  logic [1:0]      bsync1_q, bsync2_q;
  logic [1:0]      stable_q, stable_d;
  logic [1:0][7:0] dcnt_q, dcnt_d;
  logic [1:0]      press_ev;
  logic            start_ev, clear_ev;

  // Counter / FSM
  state_t      state_q;
  logic [7:0]  presc_q;
  logic [15:0] bcd_q, bcd_inc;
  logic        wrap_step;
  logic        running_q, paused_q, wrap_q;

  assign btn_raw  = {btn_clear, btn_start};
  assign tick     = k_sync_q[1] & ~k_sync_q[2];
  assign start_ev = press_ev[0];
  assign clear_ev = press_ev[1];

  // Synchronise the 1 kHz clock and delay it one cycle for edge detection
  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) k_sync_q <= '0;
    else       k_sync_q <= {k_sync_q[1:0], clk_1k_in};
  end

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      bsync1_q <= '0;
      bsync2_q <= '0;
    end else begin
      bsync1_q <= btn_raw;
      bsync2_q <= bsync1_q;
    end
  end

  // Debounce next-state; the press event fires on the accepting tick itself
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    press_ev = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (tick) begin
        if (bsync2_q[i] == stable_q[i]) begin
          dcnt_d[i] = '0;
        end else if ((dcnt_q[i] + 8'd1) == DEB_LIM) begin
          stable_d[i] = bsync2_q[i];
          dcnt_d[i]   = '0;
          press_ev[i] = bsync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      dcnt_q   <= '0;
    end else begin
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // BCD ripple increment; carry out of the top digit marks the wrap
  always_comb begin
    logic carry;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (bcd_q[d*4 +: 4] >= 4'd9) begin
          bcd_inc[d*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    wrap_step = carry;
  end

  // FSM, prescaler, BCD count and registered status outputs
  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      bcd_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear_ev) begin
        state_q   <= ST_IDLE;
        presc_q   <= '0;
        bcd_q     <= '0;
        running_q <= 1'b0;
        paused_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            presc_q <= '0;
            if (start_ev) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (tick) begin
              if (presc_q == PRES_MAX) begin
                presc_q <= '0;
                bcd_q   <= bcd_inc;
                wrap_q  <= wrap_step;
              end else begin
                presc_q <= presc_q + 8'd1;
              end
            end
            if (start_ev) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (start_ev) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bcd_out = bcd_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_1ms.sv
// Bench for stopwatch_1ms: a default instance (PRESC=10, DEB_MS=20) and a
// fast instance (PRESC=1, DEB_MS=2) for the wrap scenario, sharing clocks.
module tb_stopwatch_1ms;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        k1  = 1'b0;
  logic        bs_a = 1'b0, bc_a = 1'b0, bs_b = 1'b0, bc_b = 1'b0;
  logic [15:0] bcd_a, bcd_b;
  logic        run_a, pau_a, wrap_a, run_b, pau_b, wrap_b;

  int checks = 0;
  int failures = 0;
  int wrap_a_cnt = 0, wrap_b_cnt = 0, rise_a = 0;
  logic run_a_prev = 1'b0;

  typedef struct {
    logic [15:0] bcd;
    logic        run;
    logic        pau;
  } exp_t;
  exp_t sb[$];

  stopwatch_1ms dut_a (
    .clk_in_50M(clk), .reset(rst), .clk_1k_in(k1),
    .btn_start(bs_a), .btn_clear(bc_a),
    .bcd_out(bcd_a), .running(run_a), .paused(pau_a), .wrap(wrap_a)
  );

  stopwatch_1ms #(.PRESC(1), .DEB_MS(2)) dut_b (
    .clk_in_50M(clk), .reset(rst), .clk_1k_in(k1),
    .btn_start(bs_b), .btn_clear(bc_b),
    .bcd_out(bcd_b), .running(run_b), .paused(pau_b), .wrap(wrap_b)
  );

  always #10 clk = ~clk;

  // Count wrap-high cycles and start events (running rises) on the off edge
  always @(negedge clk) begin
    wrap_a_cnt <= wrap_a_cnt + int'(wrap_a);
    wrap_b_cnt <= wrap_b_cnt + int'(wrap_b);
    if (run_a && !run_a_prev) rise_a <= rise_a + 1;
    run_a_prev <= run_a;
  end

  // One full 1 kHz period (compressed to 4 clocks); its tick has been acted on at return
  task automatic do_tick();
    @(negedge clk) k1 = 1'b1;
    @(negedge clk);
    @(negedge clk) k1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bcd_a !== 16'h0000 || run_a !== 1'b0 || pau_a !== 1'b0 || wrap_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got bcd=%h run=%b pau=%b wrap=%b expected 0000 0 0 0", bcd_a, run_a, pau_a, wrap_a);
    end
    sb.push_back('{16'h0000, 1'b0, 1'b0});
    ticks(10);
    e = sb.pop_front();
    checks++;
    if (bcd_a !== e.bcd || run_a !== e.run || pau_a !== e.pau) begin
      failures++;
      $display("FAIL idle_ticks: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_a, run_a, pau_a, e.bcd, e.run, e.pau);
    end
    checks++;
    if (wrap_a_cnt !== 0) begin
      failures++;
      $display("FAIL idle_wrap: got %0d wrap cycles expected 0", wrap_a_cnt);
    end
  endtask

  task automatic test_start();
    exp_t e;
    int r0;
    r0 = rise_a;
    bs_a = 1'b1;
    ticks(19);
    checks++;
    if (run_a !== 1'b0) begin
      failures++;
      $display("FAIL start_early: got running=%b expected 0", run_a);
    end
    sb.push_back('{16'h0000, 1'b1, 1'b0});
    ticks(1);
    e = sb.pop_front();
    checks++;
    if (bcd_a !== e.bcd || run_a !== e.run || pau_a !== e.pau) begin
      failures++;
      $display("FAIL start_enter: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_a, run_a, pau_a, e.bcd, e.run, e.pau);
    end
    ticks(10);
    bs_a = 1'b0;
    sb.push_back('{16'h0010, 1'b1, 1'b0});
    ticks(90);
    e = sb.pop_front();
    checks++;
    if (bcd_a !== e.bcd || run_a !== e.run || pau_a !== e.pau) begin
      failures++;
      $display("FAIL start_count: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_a, run_a, pau_a, e.bcd, e.run, e.pau);
    end
    checks++;
    if (rise_a !== r0 + 1) begin
      failures++;
      $display("FAIL start_events: got %0d expected %0d", rise_a - r0, 1);
    end
  endtask

  task automatic test_bounce();
    int r0;
    bc_a = 1'b1;
    ticks(20);
    checks++;
    if (bcd_a !== 16'h0000 || run_a !== 1'b0 || pau_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: got bcd=%h run=%b pau=%b expected 0000 0 0", bcd_a, run_a, pau_a);
    end
    bc_a = 1'b0;
    ticks(25);
    r0 = rise_a;
    for (int seg = 0; seg < 12; seg++) begin
      bs_a = (seg % 2 == 0);
      ticks(5);
    end
    bs_a = 1'b0;
    ticks(25);
    checks++;
    if (bcd_a !== 16'h0000 || run_a !== 1'b0 || pau_a !== 1'b0 || rise_a !== r0) begin
      failures++;
      $display("FAIL bounce: got bcd=%h run=%b pau=%b events=%0d expected 0000 0 0 0", bcd_a, run_a, pau_a, rise_a - r0);
    end
  endtask

  task automatic test_pause_resume();
    exp_t e;
    bs_a = 1'b1;
    ticks(20);
    bs_a = 1'b0;
    ticks(233);
    bs_a = 1'b1;
    sb.push_back('{16'h0025, 1'b0, 1'b1});
    ticks(20);
    bs_a = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bcd_a !== e.bcd || run_a !== e.run || pau_a !== e.pau) begin
      failures++;
      $display("FAIL pause_enter: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_a, run_a, pau_a, e.bcd, e.run, e.pau);
    end
    sb.push_back('{16'h0025, 1'b0, 1'b1});
    ticks(300);
    e = sb.pop_front();
    checks++;
    if (bcd_a !== e.bcd || run_a !== e.run || pau_a !== e.pau) begin
      failures++;
      $display("FAIL pause_hold: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_a, run_a, pau_a, e.bcd, e.run, e.pau);
    end
    bs_a = 1'b1;
    ticks(20);
    bs_a = 1'b0;
    checks++;
    if (run_a !== 1'b1 || pau_a !== 1'b0 || bcd_a !== 16'h0025) begin
      failures++;
      $display("FAIL resume: got bcd=%h run=%b pau=%b expected 0025 1 0", bcd_a, run_a, pau_a);
    end
    ticks(6);
    checks++;
    if (bcd_a !== 16'h0025) begin
      failures++;
      $display("FAIL resume_presc_a: got %h expected 0025", bcd_a);
    end
    ticks(1);
    checks++;
    if (bcd_a !== 16'h0026) begin
      failures++;
      $display("FAIL resume_presc_b: got %h expected 0026", bcd_a);
    end
  endtask

  task automatic test_clear_reset();
    int r0;
    ticks(20);
    bs_a = 1'b1;
    bc_a = 1'b1;
    ticks(20);
    checks++;
    if (bcd_a !== 16'h0000 || run_a !== 1'b0 || pau_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_wins: got bcd=%h run=%b pau=%b expected 0000 0 0", bcd_a, run_a, pau_a);
    end
    bs_a = 1'b0;
    bc_a = 1'b0;
    ticks(25);
    bs_a = 1'b1;
    ticks(20);
    bs_a = 1'b0;
    ticks(50);
    checks++;
    if (bcd_a !== 16'h0005 || run_a !== 1'b1) begin
      failures++;
      $display("FAIL rerun: got bcd=%h run=%b expected 0005 1", bcd_a, run_a);
    end
    bs_a = 1'b1;
    r0 = rise_a;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bcd_a !== 16'h0000 || run_a !== 1'b0 || pau_a !== 1'b0 || wrap_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got bcd=%h run=%b pau=%b wrap=%b expected 0000 0 0 0", bcd_a, run_a, pau_a, wrap_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks(19);
    checks++;
    if (run_a !== 1'b0) begin
      failures++;
      $display("FAIL held_early: got running=%b expected 0", run_a);
    end
    ticks(1);
    checks++;
    if (run_a !== 1'b1) begin
      failures++;
      $display("FAIL held_start: got running=%b expected 1", run_a);
    end
    ticks(30);
    bs_a = 1'b0;
    checks++;
    if (rise_a !== r0 + 1 || run_a !== 1'b1) begin
      failures++;
      $display("FAIL held_events: got %0d running=%b expected 1 1", rise_a - r0, run_a);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int w0;
    bs_b = 1'b1;
    ticks(1);
    checks++;
    if (run_b !== 1'b0) begin
      failures++;
      $display("FAIL wrap_start_early: got running=%b expected 0", run_b);
    end
    ticks(1);
    bs_b = 1'b0;
    checks++;
    if (run_b !== 1'b1 || bcd_b !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_start: got bcd=%h run=%b expected 0000 1", bcd_b, run_b);
    end
    for (int v = 1; v <= 9999; v++) begin
      sb.push_back('{to_bcd(v), 1'b1, 1'b0});
      do_tick();
      e = sb.pop_front();
      checks++;
      if (bcd_b !== e.bcd || run_b !== e.run || pau_b !== e.pau) begin
        failures++;
        $display("FAIL wrap_count: got bcd=%h run=%b pau=%b expected %h %b %b", bcd_b, run_b, pau_b, e.bcd, e.run, e.pau);
      end
      checks++;
      if (bcd_b[3:0] > 4'd9 || bcd_b[7:4] > 4'd9 || bcd_b[11:8] > 4'd9 || bcd_b[15:12] > 4'd9) begin
        failures++;
        $display("FAIL digit_range: got %h expected all digits <= 9", bcd_b);
      end
    end
    w0 = wrap_b_cnt;
    checks++;
    if (w0 !== 0) begin
      failures++;
      $display("FAIL wrap_early: got %0d wrap cycles expected 0", w0);
    end
    do_tick();
    repeat (2) @(negedge clk);
    checks++;
    if (bcd_b !== 16'h0000 || run_b !== 1'b1 || wrap_b_cnt !== 1) begin
      failures++;
      $display("FAIL wrap_roll: got bcd=%h run=%b wrap_cycles=%0d expected 0000 1 1", bcd_b, run_b, wrap_b_cnt);
    end
    ticks(3);
    checks++;
    if (bcd_b !== 16'h0003 || wrap_b_cnt !== 1) begin
      failures++;
      $display("FAIL wrap_after: got bcd=%h wrap_cycles=%0d expected 0003 1", bcd_b, wrap_b_cnt);
    end
    checks++;
    if (wrap_a_cnt !== 0) begin
      failures++;
      $display("FAIL wrap_default_inst: got %0d wrap cycles expected 0", wrap_a_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_pause_resume();
    test_clear_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_1ms.md
Name: stopwatch_1ms

Overview:
- Stopwatch core clocked at 50 MHz, advanced by the 1 kHz divided clock `clk_out_1K` from the divider stage.
- Edge-detects `clk_out_1K` into one-cycle 1 ms ticks.
- Debounces two raw push-buttons, start/stop and clear, on those ticks.
- Runs a 4-digit BCD elapsed-time counter (SS.cc, 10 ms resolution at default) under a 3-state FSM, feeding the display stage.

Parameters:
- PRESC, 10, number of 1 ms ticks per count step (10 gives hundredths of a second); legal 1..255
- DEB_MS, 20, consecutive ticks a button must hold a new level before it is accepted; legal 1..255

Ports:
- clk_in_50M  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high; clears all state
- clk_1k_in  input  1  1 kHz square wave from the divider
- btn_start  input  1  raw start/stop button, active-high, asynchronous, bouncy
- btn_clear  input  1  raw clear button, active-high, asynchronous, bouncy
- bcd_out  output  16  [15:12] tens of seconds, [11:8] seconds, [7:4] tenths, [3:0] hundredths
- running  output  1  high in RUN
- paused  output  1  high in PAUSE
- wrap  output  1  one-cycle pulse when the count rolls from 99.99 to 00.00

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk_in_50M. All flops are in that domain.
- Reset values: every register is 0, including synchronisers, debounce counters and prescaler. Therefore bcd_out=16'h0000, running=0, paused=0, wrap=0, state=IDLE.
- Tick generation:
  - clk_1k_in passes through a 2-flop synchroniser plus a delay flop.
  - tick = sync2 & ~sync3. It is high for exactly one clk_in_50M cycle per rising edge of clk_1k_in, 2-3 cycles after that edge.
  - A falling edge produces no tick.
- Buttons, general: each button has a 2-flop synchroniser, a stable level register (reset 0) and an 8-bit debounce counter. Counters and stable levels change only on tick cycles.
- Buttons, on a tick cycle:
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments. When the incremented value reaches DEB_MS, stable takes the sync value and the counter clears.
  - A press is accepted only after DEB_MS consecutive differing ticks; any tick with sync == stable restarts the count.
- Press event: a one-cycle pulse when a stable level goes 0->1. Release (1->0) produces no event. Holding a button gives exactly one event.
- FSM states IDLE, RUN, PAUSE:
  - IDLE + start_ev -> RUN.
  - RUN + start_ev -> PAUSE.
  - PAUSE + start_ev -> RUN.
  - clear_ev in any state -> IDLE; bcd_out, prescaler and wrap are zeroed in the same cycle.
  - start_ev and clear_ev in the same cycle: clear wins, next state is IDLE.
- Outputs: running = (state==RUN); paused = (state==PAUSE); both are registered outputs.
- Prescaler (8-bit, 0..PRESC-1):
  - Advances only on tick while in RUN.
  - On a RUN tick with prescaler == PRESC-1, it returns to 0 and one count step occurs in that same cycle.
  - Held in PAUSE; zeroed in IDLE.
  - The tick that causes IDLE->RUN is not counted, because the event fires on the debounce tick before the state changes.
- Count step: BCD ripple increment.
  - Hundredths 9 -> 0 carries into tenths; tenths 9 -> 0 carries into seconds; seconds 9 -> 0 carries into tens.
  - No digit ever holds a value above 9.
- Wrap: the step from 16'h9999 gives 16'h0000, wrap=1 for that single cycle, and the FSM stays in RUN.
- Simultaneous events:
  - A count step and start_ev in the same cycle: the step completes and the FSM moves to PAUSE.
  - A count step and clear_ev in the same cycle: clear wins, bcd_out=0.
- Asynchronous reset mid-run: all state returns to reset values immediately. Buttons held through reset release are re-debounced from stable=0, so a held start button produces exactly one start_ev after DEB_MS ticks.

Test Plan:
1. Reset, then 10 ticks with buttons low -> bcd_out=16'h0000, running=0, paused=0, wrap never 1.
2. Defaults (PRESC=10, DEB_MS=20); hold btn_start for 30 ticks then release; run 100 further ticks -> running=1 after the 20th held tick, exactly one start_ev, bcd_out=16'h0010 after 100 ticks in RUN.
3. Bounce: from IDLE, toggle btn_start every 5 ticks for 60 ticks, then leave it low -> no start_ev, state stays IDLE, bcd_out=16'h0000.
4. Pause/resume: run to bcd_out=16'h0025, debounce a start press -> paused=1, bcd_out held at 16'h0025 across 300 ticks; press again -> running=1 and counting resumes from the held prescaler value.
5. Wrap (PRESC=1, DEB_MS=2): start, run 10000 ticks -> bcd_out reaches 16'h9999, next tick gives 16'h0000 with wrap=1 for exactly one cycle, running stays 1, no digit ever above 9.
6. Clear precedence: assert btn_start and btn_clear together (identical debounce) while in RUN -> state IDLE, bcd_out=16'h0000. Then assert reset asynchronously mid-RUN, between clock edges -> all outputs 0 with no clock edge required.
